// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the MIPS Avalon-MM bus master.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_e;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_e;

    localparam int LANE_MAX_W = 512;

    // Reverses the byte order of the low `width` bits; upper bits return zero.
    function automatic logic [LANE_MAX_W-1:0] lane_swap(input logic [LANE_MAX_W-1:0] data,
                                                        input int width);
        logic [LANE_MAX_W-1:0] res;
        int nbytes;
        res    = '0;
        nbytes = width / 8;
        for (int k = 0; k < LANE_MAX_W / 8; k++) begin
            if (k < nbytes) begin
                res[8*k +: 8] = data[8*(nbytes-1-k) +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mips_bus_lane_swap.sv
// Combinational byte-lane converter between CPU (big-endian) and bus (little-endian) order.
module mips_bus_lane_swap #(
    parameter int DATA_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int NB = DATA_WIDTH / 8;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            if (BIG_ENDIAN) begin : g_swap
                assign data_o[8*gi +: 8] = data_i[8*(NB-1-gi) +: 8];
            end else begin : g_pass
                assign data_o[8*gi +: 8] = data_i[8*gi +: 8];
            end
        end
    endgenerate

endmodule

// File: rtl/mips_bus_master.sv
// Arbitrates the fetch and data ports onto one Avalon-MM master with lane
// conversion, registered read data and an optional wait-state timeout.
module mips_bus_master
    import mips_bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int TIMEOUT     = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_done,
    output logic                    i_err,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_done,
    output logic                    d_err,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    read,
    output logic                    write,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    waitrequest,
    input  logic [DATA_WIDTH-1:0]   readdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_W - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]      CNT_LIMIT  = CNT_W'(TIMEOUT);

    state_e                  state_q, state_d;
    grant_e                  gnt_q, gnt_d;
    grant_e                  last_gnt_q, last_gnt_d;
    grant_e                  pick;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    read_q, read_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   writedata_q, writedata_d;
    logic [BE_W-1:0]         byteenable_q, byteenable_d;
    logic [DATA_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic [DATA_WIDTH-1:0]   wdata_bus;
    logic [DATA_WIDTH-1:0]   rdata_cpu;

    mips_bus_lane_swap #(.DATA_WIDTH(DATA_WIDTH), .BIG_ENDIAN(BIG_ENDIAN)) u_wr_swap (
        .data_i (d_wdata),
        .data_o (wdata_bus)
    );

    mips_bus_lane_swap #(.DATA_WIDTH(DATA_WIDTH), .BIG_ENDIAN(BIG_ENDIAN)) u_rd_swap (
        .data_i (readdata),
        .data_o (rdata_cpu)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_gnt_d   = last_gnt_q;
        pick         = GNT_FETCH;
        cnt_d        = cnt_q;
        err_d        = err_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // Round-robin only matters on a tie; it then favours the port not served last.
                    if (d_req && (!i_req || !ROUND_ROBIN || last_gnt_q == GNT_FETCH)) begin
                        pick = GNT_DATA;
                    end
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    state_d    = ISSUE;
                    if (pick == GNT_DATA) begin
                        address_d    = d_addr & ALIGN_MASK;
                        read_d       = !d_we;
                        write_d      = d_we;
                        writedata_d  = wdata_bus;
                        byteenable_d = d_we ? d_be : '1;
                    end else begin
                        address_d    = i_addr & ALIGN_MASK;
                        read_d       = 1'b1;
                        write_d      = 1'b0;
                        byteenable_d = '1;
                    end
                end
            end
            ISSUE: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = read_q ? CAPTURE : DONE;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LIMIT) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                if (gnt_q == GNT_DATA) begin
                    d_rdata_d = rdata_cpu;
                end else begin
                    i_rdata_d = rdata_cpu;
                end
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            gnt_q        <= GNT_FETCH;
            last_gnt_q   <= GNT_FETCH;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_gnt_q   <= last_gnt_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign i_done     = (state_q == DONE) && (gnt_q == GNT_FETCH);
    assign d_done     = (state_q == DONE) && (gnt_q == GNT_DATA);
    assign i_err      = i_done && err_q;
    assign d_err      = d_done && err_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Self-checking bench: big-endian/fixed-priority/timeout instance plus a
// 64-bit little-endian round-robin instance.
module tb_mips_bus_master;

    localparam int TO = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 32-bit, big-endian, fixed priority, TIMEOUT=5
    logic        reset, i_req, d_req, d_we, waitrequest;
    logic [31:0] i_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_be;
    logic [31:0] i_rdata, d_rdata, address, writedata;
    logic        i_done, i_err, d_done, d_err, busy, read, write;
    logic [3:0]  byteenable;

    mips_bus_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BIG_ENDIAN(1'b1),
                      .ROUND_ROBIN(1'b0), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err), .busy(busy),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
    );

    // Instance B: 64-bit, little-endian, round robin, no timeout
    logic        b_reset, b_i_req, b_d_req, b_d_we, b_waitrequest;
    logic [31:0] b_i_addr, b_d_addr, b_address;
    logic [63:0] b_d_wdata, b_readdata, b_i_rdata, b_d_rdata, b_writedata;
    logic [7:0]  b_d_be, b_byteenable;
    logic        b_i_done, b_i_err, b_d_done, b_d_err, b_busy, b_read, b_write;

    mips_bus_master #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BIG_ENDIAN(1'b0),
                      .ROUND_ROBIN(1'b1), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(b_reset),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_done(b_i_done), .i_err(b_i_err),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata), .d_be(b_d_be),
        .d_rdata(b_d_rdata), .d_done(b_d_done), .d_err(b_d_err), .busy(b_busy),
        .address(b_address), .read(b_read), .write(b_write), .writedata(b_writedata),
        .byteenable(b_byteenable), .waitrequest(b_waitrequest), .readdata(b_readdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] m_i_rdata, m_d_rdata;

    typedef struct {
        bit          is_data;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          nwait;
        logic [31:0] bus_rd;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] x);
        return {<<8{x}};
    endfunction

    task automatic run_xfer(input string tag, input vec_t v);
        bit is_wr;
        bit timed_out;
        int strobe_cycles;
        int done_cyc;
        is_wr         = v.is_data && v.we;
        timed_out     = (v.nwait > TO);
        strobe_cycles = timed_out ? TO + 1 : v.nwait + 1;
        done_cyc      = strobe_cycles + ((!is_wr && !timed_out) ? 2 : 1);
        @(negedge clk);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        waitrequest = 1'b0;
        readdata    = $urandom;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(negedge clk);
            readdata = (c == strobe_cycles + 1) ? v.bus_rd : $urandom;
            if (c <= strobe_cycles) begin
                chk({tag, " strobe"}, {read, write}, is_wr ? 2'b01 : 2'b10);
                chk({tag, " address"}, address, v.exp_addr);
                chk({tag, " byteenable"}, byteenable, v.exp_be);
                if (is_wr) chk({tag, " writedata"}, writedata, v.exp_wdata);
                chk({tag, " done early"}, {i_done, d_done}, 2'b00);
                waitrequest = (c <= v.nwait);
            end else if (c < done_cyc) begin
                chk({tag, " capture strobe"}, {read, write, busy}, 3'b001);
                chk({tag, " capture done"}, {i_done, d_done}, 2'b00);
                waitrequest = 1'($urandom_range(0, 1));
            end else if (c == done_cyc) begin
                chk({tag, " done"}, {i_done, d_done}, v.is_data ? 2'b01 : 2'b10);
                chk({tag, " err"}, {i_err, d_err}, v.exp_err ? (v.is_data ? 2'b01 : 2'b10) : 2'b00);
                if (v.is_data) m_d_rdata = v.exp_rdata;
                else m_i_rdata = v.exp_rdata;
                chk({tag, " i_rdata"}, i_rdata, m_i_rdata);
                chk({tag, " d_rdata"}, d_rdata, m_d_rdata);
                i_req = 1'b0;
                d_req = 1'b0;
            end else begin
                chk({tag, " idle"}, {busy, i_done, d_done}, 3'b000);
            end
        end
        $display("xfer %s: port=%s we=%0b addr=%h nwait=%0d rdata=%h err=%0b", tag,
                 v.is_data ? "D" : "F", is_wr, v.addr, v.nwait, v.exp_rdata, v.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;
        reset = 1'b0; b_reset = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; waitrequest = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; readdata = 0;
        b_i_req = 0; b_d_req = 0; b_d_we = 0; b_waitrequest = 0;
        b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0; b_d_be = 0; b_readdata = 0;
        m_i_rdata = 0; m_d_rdata = 0;

        //             D  we addr          wdata         be    nw bus_rd        exp_addr      exp_wdata     ebe   exp_rdata     err
        vecs[0] = '{1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h0, 0, 32'h78563412, 32'hBFC00000, 32'h0,        4'hF, 32'h12345678, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h00002000, 32'hAABBCCDD, 4'h3, 2, 32'h0,        32'h00002000, 32'hDDCCBBAA, 4'h3, 32'h00000000, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h00001006, 32'h0,        4'h0, 1, 32'hDEADBEEF, 32'h00001004, 32'h0,        4'hF, 32'hEFBEADDE, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h00003000, 32'h0,        4'h0, 9, 32'h11111111, 32'h00003000, 32'h0,        4'hF, 32'hEFBEADDE, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h00400003, 32'h0,        4'h0, 5, 32'h01020304, 32'h00400000, 32'h0,        4'hF, 32'h04030201, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h00005008, 32'h01234567, 4'hC, 6, 32'h0,        32'h00005008, 32'h67452301, 4'hC, 32'hEFBEADDE, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset strobes", {read, write, busy}, 3'b000);
        chk("reset done/err", {i_done, d_done, i_err, d_err}, 4'b0000);
        chk("reset rdata", {i_rdata, d_rdata}, 64'h0);
        chk("reset address", address, 32'h0);
        chk("reset writedata", writedata, 32'h0);
        chk("reset byteenable", byteenable, 4'h0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_xfer($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests, fixed priority: data first, then fetch
        @(negedge clk);
        i_req = 1; i_addr = 32'h00000100;
        d_req = 1; d_we = 1; d_addr = 32'h00000200; d_wdata = 32'h11223344; d_be = 4'hF;
        waitrequest = 0;
        @(negedge clk);
        chk("prio first grant", {read, write}, 2'b01);
        chk("prio first addr", address, 32'h00000200);
        @(negedge clk);
        chk("prio first done", {i_done, d_done}, 2'b01);
        d_req = 0;
        @(negedge clk);
        chk("prio gap idle", busy, 1'b0);
        @(negedge clk);
        chk("prio second grant", {read, write}, 2'b10);
        chk("prio second addr", address, 32'h00000100);
        @(negedge clk);
        readdata = 32'hA1B2C3D4;
        @(negedge clk);
        chk("prio second done", {i_done, d_done}, 2'b10);
        m_i_rdata = 32'hD4C3B2A1;
        chk("prio second rdata", i_rdata, m_i_rdata);
        i_req = 0;
        $display("xfer prio: simultaneous D then F");

        // Reset in the middle of a stalled read
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 32'h00007000; waitrequest = 1;
        @(negedge clk);
        chk("rst-mid read", read, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst-mid strobes", {read, write, busy}, 3'b000);
        chk("rst-mid done", {i_done, d_done}, 2'b00);
        m_i_rdata = 0; m_d_rdata = 0;
        chk("rst-mid rdata", d_rdata, m_d_rdata);
        reset = 1'b1; d_req = 0; waitrequest = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst-mid no done", {i_done, d_done, busy}, 3'b000);
        end
        $display("xfer rst-mid: abandoned");
        v = '{1'b0, 1'b0, 32'h00000040, 32'h0, 4'h0, 0, 32'hCAFEF00D,
              32'h00000040, 32'h0, 4'hF, 32'h0DF0FECA, 1'b0};
        run_xfer("post-reset", v);

        // Randomized transfers checked against the reference model
        for (int i = 0; i < 40; i++) begin
            v.is_data   = 1'($urandom_range(0, 1));
            v.we        = v.is_data && 1'($urandom_range(0, 1));
            v.addr      = $urandom;
            v.wdata     = $urandom;
            v.be        = 4'($urandom);
            v.nwait     = $urandom_range(0, 7);
            v.bus_rd    = $urandom;
            v.exp_addr  = {v.addr[31:2], 2'b00};
            v.exp_wdata = swap32(v.wdata);
            v.exp_be    = v.we ? v.be : 4'hF;
            v.exp_err   = (v.nwait > TO);
            if (!v.we && !v.exp_err) v.exp_rdata = swap32(v.bus_rd);
            else v.exp_rdata = v.is_data ? m_d_rdata : m_i_rdata;
            run_xfer($sformatf("rnd%0d", i), v);
        end

        // Instance B: round robin with both ports held, 64-bit alignment
        @(negedge clk);
        b_reset = 1'b1;
        @(negedge clk);
        b_i_req = 1; b_i_addr = 32'h20000008;
        b_d_req = 1; b_d_we = 0; b_d_addr = 32'h00001003;
        b_readdata = 64'h1122334455667788;
        @(negedge clk);
        chk("rr first read", {b_read, b_write}, 2'b10);
        chk("rr unaligned addr", b_address, 32'h00001000);
        chk("rr byteenable", b_byteenable, 8'hFF);
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (b_i_done || b_d_done) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) chk($sformatf("rr%0d done timeout", t), 1'b0, 1'b1);
            chk($sformatf("rr%0d grant", t), {b_i_done, b_d_done}, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr%0d rdata", t), (t % 2 == 0) ? b_d_rdata : b_i_rdata, 64'h1122334455667788);
            $display("xfer rr%0d: expected %s", t, (t % 2 == 0) ? "D" : "F");
        end
        b_i_req = 0; b_d_req = 0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
